// File: rtl/id_ex_fwd_stage.sv
// ID/EX pipeline register with load-use bubble insertion, same-cycle WB capture
// and EX operand forwarding selects.
module id_ex_fwd_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CTRLW = 12,
    parameter int unsigned CNTW  = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [XLEN-1:0]  id_rdata1,
    input  logic [XLEN-1:0]  id_rdata2,
    input  logic [XLEN-1:0]  id_imm,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic [CTRLW-1:0] id_ctrl,
    input  logic             hold,
    input  logic             flush,
    input  logic [4:0]       mem_rd,
    input  logic             mem_regwrite,
    input  logic [4:0]       wb_rd,
    input  logic             wb_regwrite,
    input  logic [XLEN-1:0]  wb_wdata,
    output logic             ex_valid,
    output logic             ex_regwrite,
    output logic             ex_memread,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rdata1,
    output logic [XLEN-1:0]  ex_rdata2,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [CTRLW-1:0] ex_ctrl,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             stall_if_id,
    output logic [CNTW-1:0]  bubble_cnt
);

    logic hazard;
    logic wb_hit1;
    logic wb_hit2;
    logic load_bubble;

    always_comb begin
        hazard = ex_valid & ex_memread & (ex_rd != 5'd0) & id_valid &
                 ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
        stall_if_id = hazard & ~flush & ~hold;
        // Write-back in flight this cycle overrides the stale register file read.
        wb_hit1 = wb_regwrite & (wb_rd != 5'd0) & (wb_rd == id_rs1);
        wb_hit2 = wb_regwrite & (wb_rd != 5'd0) & (wb_rd == id_rs2);
        load_bubble = flush | (~hold & hazard);
    end

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic valid,
                                           input logic [4:0] mrd, input logic mrw,
                                           input logic [4:0] wrd, input logic wrw);
        logic [1:0] sel;
        sel = 2'b00;
        if (valid && rs != 5'd0) begin
            if (mrw && mrd == rs) begin
                sel = 2'b10;
            end else if (wrw && wrd == rs) begin
                sel = 2'b01;
            end
        end
        return sel;
    endfunction

    always_comb begin
        fwd_a = fwd_sel(ex_rs1, ex_valid, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
        fwd_b = fwd_sel(ex_rs2, ex_valid, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ex_valid    <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_pc       <= '0;
            ex_rdata1   <= '0;
            ex_rdata2   <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_ctrl     <= '0;
            bubble_cnt  <= '0;
        end else if (load_bubble) begin
            ex_valid    <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_pc       <= '0;
            ex_rdata1   <= '0;
            ex_rdata2   <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_ctrl     <= '0;
            // Only load-use bubbles are counted, not branch flushes.
            if (!flush && bubble_cnt != '1) begin
                bubble_cnt <= bubble_cnt + CNTW'(1);
            end
        end else if (!hold) begin
            ex_valid    <= id_valid;
            ex_regwrite <= id_valid & id_regwrite;
            ex_memread  <= id_valid & id_memread;
            ex_pc       <= id_pc;
            ex_rdata1   <= wb_hit1 ? wb_wdata : id_rdata1;
            ex_rdata2   <= wb_hit2 ? wb_wdata : id_rdata2;
            ex_imm      <= id_imm;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
            ex_ctrl     <= id_valid ? id_ctrl : '0;
        end
    end

endmodule

// File: doc/id_ex_fwd_stage.md
Name: id_ex_fwd_stage

Overview:
- ID/EX pipeline register for the five-stage core.
- Captures decoded operands and control from ID, and inserts bubbles on load-use hazards and branch flush.
- Produces the 2-bit forwarding selects that drive the EX operand-A/B three-input muxes.
- Also captures same-cycle WB write data into operands, so the register file needs no write-through.

Parameters:
- XLEN, 32, datapath width
- CTRLW, 12, width of opaque EX/MEM/WB control bundle passed through
- CNTW, 16, width of bubble performance counter

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_pc  in  XLEN  instruction PC
- id_rs1, id_rs2, id_rd  in  5 each  register indices
- id_uses_rs1, id_uses_rs2  in  1 each  instruction reads rs1/rs2
- id_rdata1, id_rdata2  in  XLEN each  register file read data
- id_imm  in  XLEN  decoded immediate
- id_regwrite, id_memread  in  1 each  writes rd / is a load
- id_ctrl  in  CTRLW  remaining control bundle
- hold  in  1  global back-pressure (data memory wait)
- flush  in  1  taken branch/jump resolved in EX
- mem_rd  in  5  rd of instruction in EX/MEM
- mem_regwrite  in  1  EX/MEM writes rd
- wb_rd  in  5  rd of instruction in MEM/WB
- wb_regwrite  in  1  MEM/WB writes rd
- wb_wdata  in  XLEN  value being written back this cycle
- ex_valid, ex_regwrite, ex_memread  out  1 each  registered
- ex_pc, ex_rdata1, ex_rdata2, ex_imm  out  XLEN each  registered
- ex_rs1, ex_rs2, ex_rd  out  5 each  registered
- ex_ctrl  out  CTRLW  registered
- fwd_a, fwd_b  out  2 each  operand mux selects
- stall_if_id  out  1  freeze PC and IF/ID this cycle
- bubble_cnt  out  CNTW  count of load-use bubbles inserted

Behaviour:
- Reset (rstn low, async): all ex_* outputs 0 and bubble_cnt 0. This makes a bubble with regwrite=0 and memread=0.
- Hazard (combinational):
  - Asserted when ex_valid & ex_memread & ex_rd!=0 & id_valid & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
  - stall_if_id = hazard & ~flush & ~hold.
- Update priority at each rising clk, highest first:
  1. flush: load a bubble. ex_valid, ex_regwrite, ex_memread and ex_ctrl become 0. Other fields are don't-care but driven 0.
  2. hold: all registers keep their values.
  3. hazard: load a bubble, and bubble_cnt increments, saturating at all-ones.
  4. Otherwise: load all id_* fields. ex_valid = id_valid. If id_valid=0, regwrite/memread/ctrl are forced 0.
- WB capture on load:
  - If wb_regwrite & wb_rd!=0 & wb_rd==id_rs1, ex_rdata1 = wb_wdata, else id_rdata1.
  - Same rule for rs2 into ex_rdata2.
  - Applies to the normal-load case only.
- Forwarding selects (combinational from registered ex_rs* and current mem/wb inputs):
  - fwd_a = 2'b10 if mem_regwrite & mem_rd!=0 & mem_rd==ex_rs1.
  - Else fwd_a = 2'b01 if wb_regwrite & wb_rd!=0 & wb_rd==ex_rs1.
  - Else fwd_a = 2'b00.
  - fwd_b uses the same rule on ex_rs2.
  - Encoding: 00 = register operand, 01 = WB result, 10 = EX/MEM ALU result. 11 is never produced.
  - EX/MEM has priority when both stages match.
  - Selects are driven 00 when ex_valid=0.
- Register x0 never forwards, captures, or causes a hazard.
- Latency: one cycle from ID to EX. Selects are valid in the same cycle as the ex_* fields they qualify.
- If reset is asserted mid-stall, the next cycle after release shows a bubble and stall_if_id=0.

Test Plan:
- Reset with rstn=0 while clk toggles, then release -> all ex_* = 0, fwd_a/fwd_b=00, stall_if_id=0, bubble_cnt=0.
- Back-to-back "add x5" then "sub using x5":
  - At EX of sub, mem_rd=5 with mem_regwrite=1 -> fwd_a=10.
  - Same with wb_rd=5 only -> fwd_a=01.
  - Both stages matching -> fwd_a=10.
  - Any rs=0 match -> 00.
- "lw x7" in EX, ID "add x8,x7,x1" with id_uses_rs1=1:
  - stall_if_id=1, and the next cycle shows ex_valid=0 and bubble_cnt=1.
  - The cycle after shows the add loaded with ex_rs1=7.
- Load-use hazard with flush=1 in the same cycle -> stall_if_id=0, bubble loaded, bubble_cnt unchanged.
- Load-use hazard with hold=1 -> stall_if_id=0, all ex_* unchanged, bubble_cnt unchanged.
- Capture and saturation:
  - id_rs2=9, id_rdata2=0x0, wb_rd=9, wb_regwrite=1, wb_wdata=0xDEADBEEF -> ex_rdata2=0xDEADBEEF.
  - 65540 consecutive bubbles -> bubble_cnt saturates at 0xFFFF.
